pixel_palette_pipe: RTL and testbench

Pipelined, programmable colour-lookup stage between the tile/sprite fetch logic and the VGA output registers of the Pac-Man renderer. It turns a layer select plus a map-tile or character palette index into 8-bit R/G/B. Each palette entry can be rewritten at runtime during blanking. A frame-counted blink mode (frightened-ghost flashing) substitutes a fixed colour on the character layer. Output is fully registered with a fixed 2-cycle latency.

---
 rtl/pixel_palette_pipe.sv | 189 ++++++++++++++++++
 tb/tb_pixel_palette_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_palette_pipe.sv
// pixel_palette_pipe
//   Two-stage colour lookup between tile/sprite fetch and the VGA output
//   registers. A layer select plus a character or map palette index becomes
//   8-bit R/G/B, two clocks after the request. Both palettes are register
//   arrays that can be rewritten while the display is blanked. A
//   frame-counted blink substitutes BLINK_RGB on the character layer.
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_valid, i_mem_select    pixel request and layer (11 char, 01 map, else blank)
//   i_address_char/_map      palette indices
//   i_frame_start            one pulse per frame, drives the blink counter
//   i_blink_en               enable blink substitution on the character layer
//   i_blank                  blanking interval; writes are only taken here
//   i_wr_*                   palette write request
//   o_wr_ready, o_wr_err     write accepted / accepted write was out of range
//   o_valid, o_VGA_R/G/B     registered pixel output
module pixel_palette_pipe #(
  parameter int          CHAR_DEPTH   = 16,
  parameter int          MAP_DEPTH    = 4,
  parameter int          CHAR_AW      = 8,
  parameter int          MAP_AW       = 5,
  parameter int          BLINK_FRAMES = 16,
  parameter logic [23:0] BLINK_RGB    = 24'hFFFFFF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [1:0]         i_mem_select,
  input  logic [CHAR_AW-1:0] i_address_char,
  input  logic [MAP_AW-1:0]  i_address_map,
  input  logic               i_frame_start,
  input  logic               i_blink_en,
  input  logic               i_blank,
  input  logic               i_wr_en,
  input  logic               i_wr_layer,
  input  logic [7:0]         i_wr_addr,
  input  logic [23:0]        i_wr_rgb,
  output logic               o_wr_ready,
  output logic               o_wr_err,
  output logic               o_valid,
  output logic [7:0]         o_VGA_R,
  output logic [7:0]         o_VGA_G,
  output logic [7:0]         o_VGA_B
);

  localparam int FCW = $clog2(BLINK_FRAMES + 1);

  function automatic logic [23:0] char_dflt(input int k);
    case (k)
      0:       return 24'hFFFF00;
      1:       return 24'hFFCC00;
      2:       return 24'hFF9900;
      3:       return 24'hCC9900;
      4:       return 24'hFF0000;
      5:       return 24'hFF6600;
      6:       return 24'hFF5050;
      7:       return 24'hCC0000;
      default: return 24'h00FF00;
    endcase
  endfunction

  function automatic logic [23:0] map_dflt(input int k);
    case (k)
      0:       return 24'h000000;
      1:       return 24'hA6A6A6;
      default: return 24'h0000FF;
    endcase
  endfunction

  logic [23:0] char_pal_q [CHAR_DEPTH];
  logic [23:0] char_pal_d [CHAR_DEPTH];
  logic [23:0] map_pal_q  [MAP_DEPTH];
  logic [23:0] map_pal_d  [MAP_DEPTH];

  logic               s1_valid_q, s1_valid_d;
  logic [1:0]         s1_sel_q, s1_sel_d;
  logic [CHAR_AW-1:0] s1_char_q, s1_char_d;
  logic [MAP_AW-1:0]  s1_map_q, s1_map_d;
  logic               s1_blink_q, s1_blink_d;
  logic               valid_q, valid_d;
  logic [23:0]        rgb_q, rgb_d;
  logic [FCW-1:0]     fcnt_q, fcnt_d;
  logic               phase_q, phase_d;
  logic               wr_ready_q, wr_ready_d;
  logic               wr_err_q, wr_err_d;

  logic        wr_acc;
  logic [23:0] rd_char, rd_map, pix_rgb;

  always_comb begin
    char_pal_d = char_pal_q;
    map_pal_d  = map_pal_q;
    wr_err_d   = 1'b0;
    wr_ready_d = i_blank;
    wr_acc     = i_wr_en & wr_ready_q;

    // Decoded writes keep the address compare explicit so out-of-range
    // addresses simply match no entry.
    if (wr_acc) begin
      if (i_wr_layer) begin
        if (int'(i_wr_addr) >= CHAR_DEPTH) wr_err_d = 1'b1;
        for (int k = 0; k < CHAR_DEPTH; k++)
          if (int'(i_wr_addr) == k) char_pal_d[k] = i_wr_rgb;
      end else begin
        if (int'(i_wr_addr) >= MAP_DEPTH) wr_err_d = 1'b1;
        for (int k = 0; k < MAP_DEPTH; k++)
          if (int'(i_wr_addr) == k) map_pal_d[k] = i_wr_rgb;
      end
    end

    // Stage 1: capture the request; blink uses the phase before any toggle
    // caused by a frame pulse in this same cycle.
    s1_valid_d = i_valid;
    s1_sel_d   = i_mem_select;
    s1_char_d  = i_address_char;
    s1_map_d   = i_address_map;
    s1_blink_d = i_blink_en & phase_q & (i_mem_select == 2'b11);

    // Blink frame counter, free running.
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (i_frame_start) begin
      if (fcnt_q == FCW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // Stage 2: palette read from current register contents, so a write
    // landing on the same edge is seen only by the following pixel.
    rd_char = 24'h00FF00;
    for (int k = 0; k < CHAR_DEPTH; k++)
      if (int'(s1_char_q) == k) rd_char = char_pal_q[k];
    rd_map = 24'h0000FF;
    for (int k = 0; k < MAP_DEPTH; k++)
      if (int'(s1_map_q) == k) rd_map = map_pal_q[k];

    case (s1_sel_q)
      2'b11:   pix_rgb = s1_blink_q ? BLINK_RGB : rd_char;
      2'b01:   pix_rgb = rd_map;
      default: pix_rgb = 24'h000000;
    endcase

    valid_d = s1_valid_q;
    rgb_d   = s1_valid_q ? pix_rgb : 24'h000000;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < CHAR_DEPTH; k++) char_pal_q[k] <= char_dflt(k);
      for (int k = 0; k < MAP_DEPTH; k++)  map_pal_q[k]  <= map_dflt(k);
      s1_valid_q <= 1'b0;
      s1_sel_q   <= 2'b00;
      s1_char_q  <= '0;
      s1_map_q   <= '0;
      s1_blink_q <= 1'b0;
      valid_q    <= 1'b0;
      rgb_q      <= 24'h000000;
      fcnt_q     <= '0;
      phase_q    <= 1'b0;
      wr_ready_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      char_pal_q <= char_pal_d;
      map_pal_q  <= map_pal_d;
      s1_valid_q <= s1_valid_d;
      s1_sel_q   <= s1_sel_d;
      s1_char_q  <= s1_char_d;
      s1_map_q   <= s1_map_d;
      s1_blink_q <= s1_blink_d;
      valid_q    <= valid_d;
      rgb_q      <= rgb_d;
      fcnt_q     <= fcnt_d;
      phase_q    <= phase_d;
      wr_ready_q <= wr_ready_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign o_wr_ready = wr_ready_q;
  assign o_wr_err   = wr_err_q;
  assign o_valid    = valid_q;
  assign o_VGA_R    = rgb_q[23:16];
  assign o_VGA_G    = rgb_q[15:8];
  assign o_VGA_B    = rgb_q[7:0];

endmodule

// File: tb/tb_pixel_palette_pipe.sv
module tb_pixel_palette_pipe;
  localparam int CD = 16;
  localparam int MD = 4;
  localparam int BF = 2;

  logic        clk;
  logic        rst, vld, fs, be, blank, we, wl;
  logic [1:0]  sel;
  logic [7:0]  ca, wa;
  logic [4:0]  ma;
  logic [23:0] wd;
  logic        wr_ready, wr_err, o_valid;
  logic [7:0]  r, g, b;

  pixel_palette_pipe #(
    .CHAR_DEPTH(CD), .MAP_DEPTH(MD), .CHAR_AW(8), .MAP_AW(5),
    .BLINK_FRAMES(BF), .BLINK_RGB(24'hFFFFFF)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_mem_select(sel),
    .i_address_char(ca), .i_address_map(ma), .i_frame_start(fs),
    .i_blink_en(be), .i_blank(blank), .i_wr_en(we), .i_wr_layer(wl),
    .i_wr_addr(wa), .i_wr_rgb(wd), .o_wr_ready(wr_ready), .o_wr_err(wr_err),
    .o_valid(o_valid), .o_VGA_R(r), .o_VGA_G(g), .o_VGA_B(b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [23:0] rgb; int due; } exp_t;
  exp_t q[$];

  // Reference state
  logic [23:0] m_char [CD];
  logic [23:0] m_map  [MD];
  int          npulse;
  bit          exp_rdy [0:4095];
  bit          exp_err [0:4095];

  int errors = 0;
  int checks = 0;

  task automatic model_reset();
    m_char = '{24'hFFFF00, 24'hFFCC00, 24'hFF9900, 24'hCC9900,
               24'hFF0000, 24'hFF6600, 24'hFF5050, 24'hCC0000,
               24'h00FF00, 24'h00FF00, 24'h00FF00, 24'h00FF00,
               24'h00FF00, 24'h00FF00, 24'h00FF00, 24'h00FF00};
    m_map  = '{24'h000000, 24'hA6A6A6, 24'h0000FF, 24'h0000FF};
    npulse = 0;
  endtask

  // Apply the inputs currently driven (cycle n) to the reference model.
  task automatic model_step();
    int n;
    logic [23:0] col;
    bit phase;
    n = cyc;
    exp_err[n+1] = 1'b0;
    if (rst) begin
      model_reset();
      exp_rdy[n+1] = 1'b0;
      while (q.size() > 0 && q[$].due > n) void'(q.pop_back());
      return;
    end
    if (we && exp_rdy[n]) begin
      if (wl) begin
        if (int'(wa) < CD) m_char[int'(wa)] = wd; else exp_err[n+1] = 1'b1;
      end else begin
        if (int'(wa) < MD) m_map[int'(wa)] = wd; else exp_err[n+1] = 1'b1;
      end
    end
    exp_rdy[n+1] = blank;
    phase = ((npulse / BF) % 2) == 1;
    if (vld) begin
      if (sel == 2'b11)
        col = (be && phase) ? 24'hFFFFFF : (int'(ca) < CD ? m_char[int'(ca)] : 24'h00FF00);
      else if (sel == 2'b01)
        col = int'(ma) < MD ? m_map[int'(ma)] : 24'h0000FF;
      else
        col = 24'h000000;
      q.push_back('{rgb: col, due: n + 2});
    end
    if (fs) npulse++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld = 0; sel = 2'b00; ca = 0; ma = 0; fs = 0; we = 0; wl = 0; wa = 0; wd = 0;
  endtask

  task automatic pix(input logic [1:0] s, input logic [7:0] c, input logic [4:0] m);
    vld = 1; sel = s; ca = c; ma = m;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (wr_ready !== exp_rdy[cyc]) begin
      errors++;
      $display("FAIL wr_ready cyc=%0d got=%b want=%b", cyc, wr_ready, exp_rdy[cyc]);
    end
    checks++;
    if (wr_err !== exp_err[cyc]) begin
      errors++;
      $display("FAIL wr_err cyc=%0d got=%b want=%b", cyc, wr_err, exp_err[cyc]);
    end
    if (o_valid === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid cyc=%0d rgb=%h", cyc, {r, g, b});
      end else begin
        e = q.pop_front();
        if ({r, g, b} !== e.rgb || cyc != e.due) begin
          errors++;
          $display("FAIL pixel cyc=%0d got=%h want=%h due=%0d", cyc, {r, g, b}, e.rgb, e.due);
        end
      end
    end else begin
      checks++;
      if (o_valid !== 1'b0 || {r, g, b} !== 24'h0) begin
        errors++;
        $display("FAIL idle_out cyc=%0d valid=%b rgb=%h want 0/000000", cyc, o_valid, {r, g, b});
      end
      if (q.size() > 0 && q[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_pixel cyc=%0d want=%h due=%0d got nothing", cyc, q[0].rgb, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    rst = 1; be = 0; blank = 0; idle();
    repeat (3) tick();
    rst = 0;
    tick();

    // Defaults, including out-of-range indices and the blank layer
    for (int i = 0; i < 10; i++) begin pix(2'b11, 8'(i), 0); tick(); end
    for (int i = 0; i < 4; i++)  begin pix(2'b01, 0, 5'(i)); tick(); end
    pix(2'b10, 8'd1, 5'd1); tick();
    pix(2'b00, 8'd1, 5'd1); tick();
    idle(); tick();

    // Palette write during blank; ready appears in the second blank cycle
    blank = 1; tick();
    we = 1; wl = 1; wa = 3; wd = 24'h123456; tick();
    we = 0; blank = 0; pix(2'b11, 8'd3, 0); tick();
    idle();
    blank = 1; tick();
    we = 1; wl = 0; wa = 7; wd = 24'h111111; tick();
    we = 0; blank = 0;
    for (int i = 0; i < 4; i++) begin pix(2'b01, 0, 5'(i)); tick(); end
    idle(); tick();

    // Write outside blank is dropped
    we = 1; wl = 1; wa = 2; wd = 24'hABCDEF; tick(); tick();
    we = 0; pix(2'b11, 8'd2, 0); tick();
    idle(); tick();

    // Read/write collision on char entry 1
    blank = 1; tick();
    pix(2'b11, 8'd1, 0); tick();
    we = 1; wl = 1; wa = 1; wd = 24'h777777; tick();
    we = 0; tick();
    blank = 0; idle(); tick();

    // Blink: two pulses per half-period; map pixels never substituted
    be = 1;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) pix(2'b11, 8'd0, 0); else pix(2'b01, 0, 5'd1);
      fs = (i % 3 == 2);
      tick();
    end
    idle(); be = 0; tick();

    // Reset in the middle of a pixel stream after modifying entry 0
    blank = 1; tick();
    we = 1; wl = 1; wa = 0; wd = 24'h010203; tick();
    we = 0; blank = 0; be = 1;
    for (int i = 0; i < 5; i++) begin pix(2'b11, 8'd0, 0); fs = (i == 1); tick(); end
    fs = 0;
    rst = 1; tick();
    rst = 0;
    for (int i = 0; i < 8; i++) begin pix(2'b11, 8'd0, 0); fs = (i % 2 == 1); tick(); end
    idle(); be = 0; tick();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      vld   = ($urandom_range(0, 3) != 0);
      sel   = 2'($urandom_range(0, 3));
      ca    = 8'($urandom_range(0, 20));
      ma    = 5'($urandom_range(0, 6));
      fs    = ($urandom_range(0, 3) == 0);
      be    = ($urandom_range(0, 1) == 1);
      blank = ($urandom_range(0, 2) == 0);
      we    = ($urandom_range(0, 2) == 0);
      wl    = ($urandom_range(0, 1) == 1);
      wa    = 8'($urandom_range(0, 18));
      wd    = 24'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; be = 0; blank = 0; idle();
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
